// File: rtl/fft8_loader.sv
// Ping-pong loader: collects 8-sample frames from a valid/ready stream into two
// register banks and presents the oldest complete frame in parallel on A0..A7.
module fft8_loader #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [DATA_W-1:0] A0,
    output logic [DATA_W-1:0] A1,
    output logic [DATA_W-1:0] A2,
    output logic [DATA_W-1:0] A3,
    output logic [DATA_W-1:0] A4,
    output logic [DATA_W-1:0] A5,
    output logic [DATA_W-1:0] A6,
    output logic [DATA_W-1:0] A7,
    output logic              frame_valid,
    input  logic              frame_ack,
    output logic              err_pulse,
    output logic [7:0]        err_cnt
);

    // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
    // in_ready depends on registered state only, never on in_valid.
    logic [DATA_W-1:0] bank [2][8];
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wr_bank;
    logic              rd_bank;
    logic [2:0]        wr_idx;

    logic accept;
    logic frame_done;
    logic frame_rel;
    logic err_nxt;

    assign in_ready    = !full[wr_bank];
    assign frame_valid = full[rd_bank];
    assign accept      = in_valid && in_ready;
    assign frame_done  = accept && (wr_idx == 3'd7);
    assign frame_rel   = frame_valid && frame_ack;
    // Error when in_last disagrees with the frame position: short or misaligned frame.
    assign err_nxt     = accept && (in_last != (wr_idx == 3'd7));

    // Release and completion never target the same bank: a full bank is not writable.
    always_comb begin
        full_nxt = full;
        if (frame_rel) full_nxt[rd_bank] = 1'b0;
        if (frame_done) full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 8; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else if (accept) begin
            bank[wr_bank][wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= 3'd0;
            err_pulse <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            full <= full_nxt;
            if (frame_done) begin
                wr_bank <= ~wr_bank;
                wr_idx  <= 3'd0;
            end else if (accept && in_last) begin
                wr_idx <= 3'd0;
            end else if (accept) begin
                wr_idx <= wr_idx + 3'd1;
            end
            if (frame_rel) rd_bank <= ~rd_bank;
            err_pulse <= err_nxt;
            if (err_nxt && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign A0 = bank[rd_bank][0];
    assign A1 = bank[rd_bank][1];
    assign A2 = bank[rd_bank][2];
    assign A3 = bank[rd_bank][3];
    assign A4 = bank[rd_bank][4];
    assign A5 = bank[rd_bank][5];
    assign A6 = bank[rd_bank][6];
    assign A7 = bank[rd_bank][7];

endmodule

// File: tb/tb_fft8_loader.sv
// Bench for fft8_loader: frame-queue reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fft8_loader;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic [W-1:0]  a_w [8];
    logic          frame_valid;
    logic          frame_ack = 1'b0;
    logic          err_pulse;
    logic [7:0]    err_cnt;

    int pass_cnt = 0;
    int tot_cnt = 0;
    int cyc = 0;

    fft8_loader #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .A0(a_w[0]), .A1(a_w[1]), .A2(a_w[2]), .A3(a_w[3]),
        .A4(a_w[4]), .A5(a_w[5]), .A6(a_w[6]), .A7(a_w[7]),
        .frame_valid(frame_valid), .frame_ack(frame_ack),
        .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: queue of complete frames (oldest presented), partial frame list.
    logic [8*W-1:0] fq[$];
    logic [W-1:0]   part[$];
    logic           m_err = 1'b0;
    int             m_cnt = 0;
    logic [8*W-1:0] nf;
    bit             m_rel, m_acc, m_done, m_e;

    always @(negedge rst_n) begin
        fq.delete();
        part.delete();
        m_err = 1'b0;
        m_cnt = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            m_rel  = (fq.size() > 0) && frame_ack;
            m_acc  = in_valid && (fq.size() < 2);
            m_done = 1'b0;
            m_e    = 1'b0;
            if (m_acc) begin
                part.push_back(in_data);
                if (part.size() == 8) begin
                    for (int k = 0; k < 8; k++) nf[k*W +: W] = part[k];
                    m_done = 1'b1;
                    m_e = !in_last;
                    part.delete();
                end else if (in_last) begin
                    m_e = 1'b1;
                    part.delete();
                end
            end
            if (m_rel) void'(fq.pop_front());
            if (m_done) fq.push_back(nf);
            m_err = m_e;
            if (m_e && m_cnt < 255) m_cnt++;
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_ready, fq.size() < 2);
        check("frame_valid", frame_valid, fq.size() > 0);
        check("err_pulse", err_pulse, m_err);
        check("err_cnt", err_cnt, m_cnt[7:0]);
        if (fq.size() > 0) begin
            for (int k = 0; k < 8; k++) check($sformatf("A%0d", k), a_w[k], fq[0][k*W +: W]);
        end
    end

    // Called right after a falling edge; returns right after the falling edge
    // that follows the accepting rising edge.
    task automatic send(input logic [W-1:0] d, input logic last);
        bit ok;
        int budget = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        do begin
            ok = in_ready;
            @(negedge clk);
            budget++;
        end while (!ok && budget < 200);
        if (!ok) begin
            tot_cnt++;
            $display("FAIL send_timeout: sample %0h not accepted within 200 cycles", d);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic reset_checked(input string tag);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_rst_fv"}, frame_valid, 1'b0);
        check({tag, "_rst_rdy"}, in_ready, 1'b1);
        check({tag, "_rst_cnt"}, err_cnt, 8'd0);
        for (int k = 0; k < 8; k++) check($sformatf("%s_rst_A%0d", tag, k), a_w[k], 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int base);
        check({tag, "_fv"}, frame_valid, 1'b1);
        for (int k = 0; k < 8; k++) check($sformatf("%s_A%0d", tag, k), a_w[k], base + k);
    endtask

    initial begin
        int c0;
        #1;
        check("por_fv", frame_valid, 1'b0);
        check("por_rdy", in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single frame 1..8, no ack
        for (int i = 1; i <= 8; i++) send(i, i == 8);
        check_frame("f1", 1);
        check("f1_rdy", in_ready, 1'b1);

        // Second frame fills both banks; 17 stalls until release
        for (int i = 9; i <= 16; i++) send(i, i == 16);
        check("full_rdy", in_ready, 1'b0);
        check_frame("still_f1", 1);
        in_valid = 1'b1;
        in_data  = 17;
        repeat (3) @(negedge clk);
        check("stall_rdy", in_ready, 1'b0);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check_frame("f2", 9);
        check("rel_rdy", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;

        // Reset with a frame pending and a partial frame in progress
        reset_checked("r0");
        for (int i = 0; i < 8; i++) send(200 + i, i == 7);
        for (int i = 0; i < 5; i++) send(300 + i, 1'b0);
        reset_checked("r1");
        for (int i = 0; i < 8; i++) send(50 + i, i == 7);
        check_frame("post_rst", 50);

        // Short frame then a good one
        reset_checked("r2");
        for (int i = 0; i < 3; i++) send(i + 1, i == 2);
        for (int i = 0; i < 8; i++) send(100 + i, i == 7);
        @(negedge clk);
        check("short_cnt", err_cnt, 8'd1);
        check_frame("short", 100);

        // Continuous streaming with ack held: 4 frames in 32 cycles
        reset_checked("r3");
        frame_ack = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 32; i++) send(1000 + i, (i % 8) == 7);
        check("stream_cycles", cyc - c0, 32);
        check("stream_cnt", err_cnt, 8'd0);

        // 300 misaligned frames saturate the error counter
        for (int f = 0; f < 300; f++) begin
            for (int i = 0; i < 8; i++) send($urandom, 1'b0);
        end
        @(negedge clk);
        check("sat_cnt", err_cnt, 8'd255);
        frame_ack = 1'b0;

        // Random traffic
        reset_checked("r4");
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_last   = ($urandom_range(0, 9) == 0);
            frame_ack = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        frame_ack = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/fft8_loader.md
FFT8_LOADER -- requirements
Module: fft8_loader

Interface
REQ-001 Parameter DATA_W, default 32, width of each sample word and of each A-port.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; one clock; no other reset source.
REQ-004 in_valid  input  1  upstream sample present on in_data.
REQ-005 in_ready  output  1  loader can accept a sample this cycle.
REQ-006 in_data  input  DATA_W  time-domain sample, stream order x0..x7.
REQ-007 in_last  input  1  marks the final sample of an 8-sample frame.
REQ-008 A0..A7  output  DATA_W each  parallel frame, A<k> = sample k of the presented frame, directly feeding the 8-point FFT inputs.
REQ-009 frame_valid  output  1  A0..A7 hold a complete frame and are stable.
REQ-010 frame_ack  input  1  consumer has captured the FFT result; releases the presented frame.
REQ-011 err_pulse  output  1  one-cycle pulse on a framing error.
REQ-012 err_cnt  output  8  saturating count of framing errors.

Function
REQ-013 Storage SHALL be two banks (0, 1) of 8 x DATA_W registers, plus per-bank full flag, write bank pointer wr_bank, 3-bit write index wr_idx, read bank pointer rd_bank.
REQ-014 Sample accepted iff in_valid && in_ready on a rising clk edge; in_ready SHALL equal !full[wr_bank], combinational from registers only (no dependence on in_valid).
REQ-015 On accept: bank[wr_bank][wr_idx] <= in_data; wr_idx increments by 1.
REQ-016 Accept at wr_idx==7 SHALL set full[wr_bank], toggle wr_bank, reset wr_idx to 0, regardless of in_last.
REQ-017 Accept with in_last=1 at wr_idx<7 (short frame) SHALL discard the partial frame: wr_idx <= 0, full and wr_bank unchanged, err_pulse=1 next cycle.
REQ-018 Accept at wr_idx==7 with in_last=0 (long/misaligned frame) SHALL still complete the frame per REQ-016 and raise err_pulse next cycle.
REQ-019 err_cnt SHALL increment by 1 per err_pulse and saturate at 255.
REQ-020 frame_valid SHALL equal full[rd_bank]; A0..A7 SHALL equal bank[rd_bank][0..7] whenever frame_valid=1 and SHALL NOT change while frame_valid=1.
REQ-021 frame_valid && frame_ack on an edge SHALL clear full[rd_bank] and toggle rd_bank; frame_ack while frame_valid=0 SHALL be ignored.
REQ-022 Completion of one bank and release of the other in the same cycle SHALL both take effect; completion into bank b and release of bank b cannot coincide (bank b not writable while full).
REQ-023 Latency: last sample accepted at edge N -> frame_valid=1 after edge N if that bank is rd_bank, else after the edge following release of the other bank.
REQ-024 Throughput: with frame_ack held 1, one frame per 8 accepted samples, in_ready never deasserts.
REQ-025 Both banks full -> in_ready=0 until a release; release at edge N -> in_ready=1 after edge N.

Reset
REQ-026 rst_n=0 SHALL immediately clear both banks to 0, full[1:0]=0, wr_bank=rd_bank=0, wr_idx=0, err_cnt=0, err_pulse=0; thus A0..A7=0, frame_valid=0, in_ready=1.
REQ-027 Reset mid-frame or with frames pending SHALL discard all data; first sample after release is stored as x0 of bank 0.

Verification
REQ-028 Stream 1..8 (in_last on 8th), frame_ack=0 -> frame_valid=1 after the 8th accept, A0..A7=1..8, in_ready stays 1.
REQ-029 Continue 9..16 then 17 with frame_ack=0 -> after 16 in_ready=0, 17 stalled; pulse frame_ack -> A0..A7=9..16, in_ready=1, 17 accepted into bank 0.
REQ-030 Send 3 samples with in_last on 3rd, then 8 samples 100..107 -> err_pulse once, err_cnt=1, presented frame = 100..107.
REQ-031 Send 8 samples with in_last=0 on 8th -> frame presented, err_pulse once; 300 such frames -> err_cnt=255.
REQ-032 Continuous in_valid, frame_ack=1 -> 4 frames in 32 cycles, in_ready never 0, each frame correct.
REQ-033 Assert rst_n=0 after 5 samples with one frame pending -> frame_valid=0, A0..A7=0, in_ready=1 asynchronously; next 8 samples form frame in bank 0.
